mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_rdata_ext.sv | 28 ++
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM states, exe_mem_all bit
// positions, data_size encodings and a byte-strobe helper.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_DROP = 3'd4
  } mem_state_e;

  // Bit positions inside exe_mem_all = {mem_we,ld_b,ld_h,ld_w,ld_se,st_b,st_h,st_w}
  localparam int MA_MEM_WE = 7;
  localparam int MA_LD_B   = 6;
  localparam int MA_LD_H   = 5;
  localparam int MA_LD_W   = 4;
  localparam int MA_LD_SE  = 3;
  localparam int MA_ST_B   = 2;
  localparam int MA_ST_H   = 1;
  localparam int MA_ST_W   = 0;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 4'b0001 << addr_lo;
      SIZE_H:  return 4'b0011 << addr_lo;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_rdata_ext.sv
// Load data lane selection and sign/zero extension for the MEM stage.
module mem_rdata_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic        i_ld_b,
  input  logic        i_ld_h,
  input  logic        i_ld_se,
  output logic [31:0] o_data
);

  logic [31:0] w_shift_b;
  logic [31:0] w_shift_h;

  assign w_shift_b = i_rdata >> {i_addr, 3'b000};
  assign w_shift_h = i_rdata >> {i_addr[1], 4'b0000};

  always_comb begin
    o_data = i_rdata;
    if (i_ld_b) begin
      o_data = {{24{i_ld_se & w_shift_b[7]}}, w_shift_b[7:0]};
    end else if (i_ld_h) begin
      o_data = {{16{i_ld_se & w_shift_h[15]}}, w_shift_h[15:0]};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with an SRAM-like request/response data port.
// Optional macro MEM_ALIGN_CHECK_EN enables the address-misalignment (ale) exception.
module mem_stage
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_to_mem_valid,
  output logic        mem_allowin,
  input  logic [31:0] exe_pc,
  input  logic [31:0] exe_result,
  input  logic        exe_res_from_mem,
  input  logic [7:0]  exe_mem_all,
  input  logic [31:0] exe_rkd_value,
  input  logic [5:0]  exe_rf_all,
  input  logic [1:0]  exe_exc_rf,
  input  logic        cancel_exc_ertn,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_result,
  output logic [5:0]  mem_rf_all,
  output logic [2:0]  mem_exc_rf,
  output logic [38:0] mem_fwd_all,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  mem_state_e  r_state;
  mem_state_e  w_next_state;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_result;
  logic [31:0] r_rkd;
  logic [31:0] r_buf;
  logic        r_res_from_mem;
  logic [7:0]  r_mem_all;
  logic [5:0]  r_rf_all;
  logic [1:0]  r_exc_rf;
  logic        r_ale;

  logic        w_ready_go;
  logic        w_accept;
  logic        w_leave;
  logic        w_ale_in;
  logic        w_memop_in;
  logic        w_load_ok;
  logic        w_blocking;
  logic [1:0]  w_size;
  logic [31:0] w_raw_rdata;
  logic [31:0] w_ext_data;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_ale_in = ((exe_mem_all[MA_LD_H] | exe_mem_all[MA_ST_H]) & exe_result[0])
                  | ((exe_mem_all[MA_LD_W] | exe_mem_all[MA_ST_W]) & (|exe_result[1:0]));
`else
  assign w_ale_in = 1'b0;
`endif

  // Only clean memory ops go to the bus; faulting ones flow through as bubbles of work.
  assign w_memop_in = (exe_res_from_mem | exe_mem_all[MA_MEM_WE]) & ~(|exe_exc_rf) & ~w_ale_in;

  always_comb begin
    case (r_state)
      ST_IDLE: w_ready_go = 1'b1;
      ST_WAIT: w_ready_go = data_data_ok;
      ST_DONE: w_ready_go = 1'b1;
      default: w_ready_go = 1'b0;
    endcase
  end

  assign mem_allowin     = (r_state != ST_DROP) & (~r_valid | (w_ready_go & wb_allowin));
  assign mem_to_wb_valid = r_valid & w_ready_go;
  assign w_accept        = exe_to_mem_valid & mem_allowin & ~cancel_exc_ertn;
  assign w_leave         = mem_to_wb_valid & wb_allowin;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept & w_memop_in) w_next_state = ST_REQ;
      ST_REQ: begin
        if (cancel_exc_ertn)   w_next_state = data_addr_ok ? ST_DROP : ST_IDLE;
        else if (data_addr_ok) w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // A response arriving with the cancel needs no draining.
        if (cancel_exc_ertn)    w_next_state = data_data_ok ? ST_IDLE : ST_DROP;
        else if (data_data_ok) begin
          if (w_leave) w_next_state = (w_accept & w_memop_in) ? ST_REQ : ST_IDLE;
          else         w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (cancel_exc_ertn) w_next_state = ST_IDLE;
        else if (w_leave)    w_next_state = (w_accept & w_memop_in) ? ST_REQ : ST_IDLE;
      end
      ST_DROP: if (data_data_ok) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_next_state;
      if (cancel_exc_ertn)  r_valid <= 1'b0;
      else if (mem_allowin) r_valid <= exe_to_mem_valid;
      if (r_state == ST_WAIT && data_data_ok && !cancel_exc_ertn) r_buf <= data_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc           <= 32'd0;
      r_result       <= 32'd0;
      r_rkd          <= 32'd0;
      r_res_from_mem <= 1'b0;
      r_mem_all      <= 8'd0;
      r_rf_all       <= 6'd0;
      r_exc_rf       <= 2'd0;
      r_ale          <= 1'b0;
    end else if (w_accept) begin
      r_pc           <= exe_pc;
      r_result       <= exe_result;
      r_rkd          <= exe_rkd_value;
      r_res_from_mem <= exe_res_from_mem;
      r_mem_all      <= exe_mem_all;
      r_rf_all       <= exe_rf_all;
      r_exc_rf       <= exe_exc_rf;
      r_ale          <= w_ale_in;
    end
  end

  always_comb begin
    if (r_mem_all[MA_LD_W] | r_mem_all[MA_ST_W])      w_size = SIZE_W;
    else if (r_mem_all[MA_LD_H] | r_mem_all[MA_ST_H]) w_size = SIZE_H;
    else if (r_mem_all[MA_LD_B] | r_mem_all[MA_ST_B]) w_size = SIZE_B;
    else                                              w_size = SIZE_W;
  end

  assign data_req   = (r_state == ST_REQ);
  assign data_wr    = r_mem_all[MA_MEM_WE];
  assign data_size  = w_size;
  assign data_addr  = r_result;
  assign data_wstrb = r_mem_all[MA_MEM_WE] ? size_to_wstrb(w_size, r_result[1:0]) : 4'b0000;

  always_comb begin
    case (w_size)
      SIZE_B:  data_wdata = {4{r_rkd[7:0]}};
      SIZE_H:  data_wdata = {2{r_rkd[15:0]}};
      default: data_wdata = r_rkd;
    endcase
  end

  // Response data bypasses the buffer on the cycle it arrives.
  assign w_raw_rdata = (r_state == ST_WAIT) ? data_rdata : r_buf;

  mem_rdata_ext u_rdata_ext (
    .i_rdata (w_raw_rdata),
    .i_addr  (r_result[1:0]),
    .i_ld_b  (r_mem_all[MA_LD_B]),
    .i_ld_h  (r_mem_all[MA_LD_H]),
    .i_ld_se (r_mem_all[MA_LD_SE]),
    .o_data  (w_ext_data)
  );

  assign w_load_ok  = r_res_from_mem & ~r_ale & ~(|r_exc_rf);
  assign w_blocking = r_valid & r_res_from_mem & ~w_ready_go;

  assign mem_pc      = r_pc;
  assign mem_result  = w_load_ok ? w_ext_data : r_result;
  assign mem_rf_all  = r_rf_all;
  assign mem_exc_rf  = {r_ale, r_exc_rf};
  assign mem_fwd_all = {w_blocking, r_rf_all[5] & r_valid, r_rf_all[4:0], mem_result};

endmodule
